timer_unit: RTL and testbench

TIMER_UNIT -- requirements
Module: timer_unit

---
 rtl/timer_unit.sv | 186 ++++++++++++++++++
 tb/tb_timer_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_unit.sv
// timer_unit: memory-mapped down-counting timer with a three-register window
// (CTRL, PRESET, COUNT), one-shot or auto-reload operation and a registered,
// maskable interrupt request.
module timer_unit #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_7f00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    // Word offsets inside the register window (addr[3:2]).
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // MODE encoding: only 2'b01 reloads; every other value is one-shot.
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        int_flag_q, int_flag_d;
    logic        irq_q;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_reload;
    logic        hw_en_clr;
    logic        flag_set;
    logic        flag_clr_hw;

    // Only addr[3:2] selects a register; the window base is decoded upstream,
    // so the remaining address bits and the base parameter are deliberately
    // folded into a sink.
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], ADDR_BASE};

    // Write-strobe decode for the two writable registers.
    always_comb begin
        wr_ctrl   = we && (addr[3:2] == OFF_CTRL);
        wr_preset = we && (addr[3:2] == OFF_PRESET);
    end

    assign auto_reload = (mode_q == MODE_RELOAD);

    // Next-state and datapath logic of the counting FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case below can leave a value unassigned (latch).
        state_d     = state_q;
        count_d     = count_q;
        hw_en_clr   = 1'b0;
        flag_set    = 1'b0;
        flag_clr_hw = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = en_q ? ST_CNT : ST_IDLE;
            end
            ST_CNT: begin
                if (!en_q) begin
                    // Disabled mid-count: COUNT is left frozen.
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Saturate at zero so PRESET=0/1 never wraps.
                    count_d  = 32'd0;
                    state_d  = ST_INT;
                    flag_set = 1'b1;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    state_d     = ST_LOAD;
                    flag_clr_hw = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    hw_en_clr = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register-file next values; a software CTRL write overrides the
    // hardware EN clear issued from INT in one-shot mode.
    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;

        if (hw_en_clr) begin
            en_d = 1'b0;
        end
        if (wr_ctrl) begin
            en_d   = wdata[0];
            mode_d = wdata[2:1];
            im_d   = wdata[3];
        end
        if (wr_preset) begin
            preset_d = wdata;
        end
    end

    // Interrupt flag: a new expiry wins over any clear in the same cycle.
    always_comb begin
        int_flag_d = int_flag_q;
        if (flag_clr_hw || ((wr_ctrl || wr_preset) && !auto_reload)) begin
            int_flag_d = 1'b0;
        end
        if (flag_set) begin
            int_flag_d = 1'b1;
        end
    end

    // State and register storage with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            int_flag_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            int_flag_q <= int_flag_d;
        end
    end

    // irq is a flop output so nothing on the bus can glitch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= im_q & int_flag_q;
        end
    end

    assign irq = irq_q;

    // Combinational read mux; the unmapped slot reads as zero.
    always_comb begin
        rdata = 32'd0;
        unique case (addr[3:2])
            OFF_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
            OFF_PRESET: rdata = preset_q;
            OFF_COUNT:  rdata = count_q;
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: register-access vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_timer_unit;

    localparam logic [31:0] BASE = 32'h0000_7f00;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_vec;
    int n_err;

    timer_unit #(.ADDR_BASE(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Phases of a timer period as described by its rules.
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_EXP  = 3;

    int          m_phase;
    bit          m_en;
    bit [1:0]    m_mode;
    bit          m_im;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_flag;
    bit          m_irq;

    task automatic model_reset();
        m_phase = P_IDLE; m_en = 0; m_mode = 0; m_im = 0;
        m_preset = 0; m_count = 0; m_flag = 0; m_irq = 0;
    endtask

    // Advance the model by one clock using the bus inputs the DUT will sample.
    task automatic model_step();
        int          np;
        logic [31:0] nc;
        bit          ne, nim, nf, expired, cleared, reload;
        bit [1:0]    nm;
        logic [31:0] npre;
        np = m_phase; nc = m_count; ne = m_en; nm = m_mode; nim = m_im;
        npre = m_preset; nf = m_flag; expired = 0; cleared = 0;
        reload = (m_mode == 2'b01);
        if (m_phase == P_IDLE) begin
            if (m_en) np = P_LOAD;
        end else if (m_phase == P_LOAD) begin
            nc = m_preset;
            np = m_en ? P_RUN : P_IDLE;
        end else if (m_phase == P_RUN) begin
            if (!m_en) np = P_IDLE;
            else begin
                nc = (m_count > 1) ? m_count - 1 : 32'd0;
                if (m_count <= 1) begin np = P_EXP; expired = 1; end
            end
        end else begin
            if (reload) begin np = P_LOAD; cleared = 1; end
            else begin np = P_IDLE; ne = 0; end
        end
        if (we && addr[3:2] == 2'd0) begin
            ne = wdata[0]; nm = wdata[2:1]; nim = wdata[3];
            if (!reload) cleared = 1;
        end
        if (we && addr[3:2] == 2'd1) begin
            npre = wdata;
            if (!reload) cleared = 1;
        end
        if (cleared) nf = 0;
        if (expired) nf = 1;
        m_irq = m_im & m_flag;
        m_phase = np; m_count = nc; m_en = ne; m_mode = nm; m_im = nim;
        m_preset = npre; m_flag = nf;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic do_reset();
        we = 1'b0; addr = BASE; wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- register-access vector table ----------------
    typedef struct {
        bit          do_wr;
        logic [31:0] wr_off;
        logic [31:0] wdata;
        logic [31:0] rd_off;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        n_vec = 0;
        n_err = 0;
        do_reset();

        tbl[0]  = '{0, 32'h0, 32'h0,         32'h0, 32'h0};
        tbl[1]  = '{0, 32'h0, 32'h0,         32'h4, 32'h0};
        tbl[2]  = '{0, 32'h0, 32'h0,         32'h8, 32'h0};
        tbl[3]  = '{0, 32'h0, 32'h0,         32'hc, 32'h0};
        tbl[4]  = '{1, 32'h4, 32'hdead_beef, 32'h4, 32'hdead_beef};
        tbl[5]  = '{1, 32'h0, 32'hffff_fff6, 32'h0, 32'h6};
        tbl[6]  = '{1, 32'h8, 32'h1234_5678, 32'h8, 32'h0};
        tbl[7]  = '{1, 32'hc, 32'hffff_ffff, 32'hc, 32'h0};
        tbl[8]  = '{0, 32'h0, 32'h0,         32'h4, 32'hdead_beef};
        tbl[9]  = '{1, 32'h0, 32'h0000_000e, 32'h0, 32'he};
        tbl[10] = '{1, 32'h4, 32'ha5a5_0001, 32'h4, 32'ha5a5_0001};
        tbl[11] = '{1, 32'h0, 32'h0000_0000, 32'h0, 32'h0};

        chk_irq("reset_irq", 1'b0);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].do_wr) wr(BASE + tbl[i].wr_off, tbl[i].wdata);
            chk_rd($sformatf("tbl%0d", i), BASE + tbl[i].rd_off, tbl[i].exp);
        end

        // One-shot, PRESET=5, IM=1: COUNT 5..0, irq lags by one cycle, sticks.
        do_reset();
        wr(BASE + 32'h4, 32'd5);
        wr(BASE + 32'h0, 32'h9);
        tick();
        tick();
        chk_rd("os_count5", BASE + 32'h8, 32'd5);
        for (int v = 4; v >= 0; v--) begin
            tick();
            chk_rd($sformatf("os_count%0d", v), BASE + 32'h8, v);
        end
        chk_irq("os_irq_lag", 1'b0);
        tick();
        chk_irq("os_irq_rise", 1'b1);
        chk_rd("os_ctrl_en_clr", BASE + 32'h0, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_irq("os_irq_hold", 1'b1);
        end
        wr(BASE + 32'h0, 32'h8);
        tick();
        chk_irq("os_irq_clr", 1'b0);
        chk_rd("os_count_hold", BASE + 32'h8, 32'd0);

        // Auto-reload, PRESET=3: 1-cycle irq pulse every 5 cycles.
        do_reset();
        wr(BASE + 32'h4, 32'd3);
        wr(BASE + 32'h0, 32'hb);
        for (int i = 1; i <= 26; i++) begin
            tick();
            chk_irq($sformatf("ar_irq_c%0d", i), (i >= 6) && ((i - 6) % 5 == 0));
        end

        // Disable mid-count freezes COUNT; re-enable reloads from PRESET.
        do_reset();
        wr(BASE + 32'h4, 32'd20);
        wr(BASE + 32'h0, 32'h1);
        repeat (12) tick();
        chk_rd("dis_count10", BASE + 32'h8, 32'd10);
        wr(BASE + 32'h0, 32'h0);
        tick();
        chk_rd("dis_frozen", BASE + 32'h8, 32'd9);
        repeat (3) tick();
        chk_rd("dis_still", BASE + 32'h8, 32'd9);
        wr(BASE + 32'h0, 32'h1);
        tick();
        tick();
        chk_rd("dis_reload", BASE + 32'h8, 32'd20);

        // PRESET 0 and 1: INT on the third cycle, no underflow.
        for (int p = 0; p < 2; p++) begin
            do_reset();
            wr(BASE + 32'h4, p);
            wr(BASE + 32'h0, 32'h9);
            tick();
            tick();
            chk_rd($sformatf("min%0d_load", p), BASE + 32'h8, p);
            tick();
            chk_rd($sformatf("min%0d_zero", p), BASE + 32'h8, 32'd0);
            chk_irq($sformatf("min%0d_irq_lo", p), 1'b0);
            tick();
            chk_irq($sformatf("min%0d_irq_hi", p), 1'b1);
            chk_rd($sformatf("min%0d_nowrap", p), BASE + 32'h8, 32'd0);
        end

        // CTRL write in the same cycle as the hardware EN clear wins.
        do_reset();
        wr(BASE + 32'h4, 32'd2);
        wr(BASE + 32'h0, 32'h9);
        repeat (4) tick();
        wr(BASE + 32'h0, 32'h9);
        chk_rd("race_ctrl", BASE + 32'h0, 32'h9);
        tick();
        tick();
        chk_rd("race_restart", BASE + 32'h8, 32'd2);

        // Asynchronous reset between edges while COUNT=7.
        do_reset();
        wr(BASE + 32'h4, 32'd20);
        wr(BASE + 32'h0, 32'h9);
        repeat (15) tick();
        chk_rd("ar_count7", BASE + 32'h8, 32'd7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_count", rdata, 32'd0);
        chk_irq("arst_irq", 1'b0);
        chk_rd("arst_ctrl", BASE + 32'h0, 32'd0);
        chk_rd("arst_preset", BASE + 32'h4, 32'd0);
        #1;
        rst_n = 1'b1;
        wr(BASE + 32'h8, 32'h55);
        chk_rd("arst_cnt_wr", BASE + 32'h8, 32'd0);
        repeat (3) tick();
        chk_rd("arst_idle", BASE + 32'h8, 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            logic [1:0]  off;
            r = $urandom();
            if ($urandom_range(0, 7) == 0) begin
                off = 2'($urandom_range(0, 3));
                we = 1'b1;
                addr = BASE + {28'd0, off, 2'b00};
                if (off == 2'd0)      wdata = {r[31:1], 1'($urandom_range(0, 3) != 0)};
                else if (off == 2'd1) wdata = ($urandom_range(0, 9) == 0) ? r : 32'($urandom_range(0, 12));
                else                  wdata = r;
            end
            tick();
            we = 1'b0;
            off = 2'($urandom_range(0, 3));
            addr = BASE + {28'd0, off, 2'b00};
            #1;
            check($sformatf("rnd_rd%0d_off%0d", i, off), rdata, model_read(off));
            chk_irq($sformatf("rnd_irq%0d", i), m_irq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
